// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration command parser.
// Used by cfg_cmd_parser and cfg_idle_timer.
package cfg_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 7;

  localparam logic [7:0] FUNCT_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_FUNC,
    ST_DATA,
    ST_CHK,
    ST_COMMIT
  } state_e;

  // Bits needed to hold 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/cfg_idle_timer.sv
// Idle down-counter: reloads on clr, counts down while en, flags expire at 0.
// CYC = 0 disables expiry entirely.
module cfg_idle_timer
  import cfg_pkg::*;
#(
  parameter int CYC = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = clog2(CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = W'(CYC);
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= W'(CYC);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (CYC != 0) && en && (cnt_q == '0);

endmodule

// File: rtl/cfg_cmd_parser.sv
// Framed byte-stream parser writing a bank of configuration registers.
// Define CFG_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module cfg_cmd_parser
  import cfg_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS =
    {16'd1000, 16'd10, 16'd5, 16'd30, 16'd20, 16'd10, 16'd0},
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
  output logic                       wr_pulse,
  output logic [7:0]                 wr_idx,
  output logic                       err_pulse,
  output logic                       busy
);

  localparam int NB   = DATA_W / 8;
  localparam int BC_W = clog2(NB + 1);

  state_e state_q, state_d;

  logic [7:0]                 funct_q, funct_d;
  logic [DATA_W-1:0]          sh_q, sh_d;
  logic [BC_W-1:0]            bc_q, bc_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic                       wr_pulse_q, wr_pulse_d;
  logic                       err_pulse_q, err_pulse_d;
  logic [7:0]                 wr_idx_q, wr_idx_d;

  logic accept;
  logic timeout;
  logic last_data;
  logic funct_hi;
  logic chk_bad;
  logic tmr_en;

  assign rx_ready  = (state_q != ST_COMMIT);
  assign accept    = rx_valid && rx_ready && !timeout;
  assign last_data = (bc_q == BC_W'(NB - 1));
  assign funct_hi  = (funct_q > 8'(NUM_REGS));
  assign tmr_en    = (state_q == ST_DATA) || (state_q == ST_CHK);

  cfg_idle_timer #(
    .CYC (TIMEOUT_CYC)
  ) u_idle (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (accept || !tmr_en),
    .en     (tmr_en),
    .expire (timeout)
  );

`ifdef CFG_CHECKSUM_EN
  localparam state_e ST_AFTER = ST_CHK;

  logic [7:0] xor_q, xor_d;
  logic       bad_q, bad_d;

  always_comb begin
    xor_d = xor_q;
    bad_d = bad_q;
    if (accept) begin
      unique case (state_q)
        ST_FUNC: begin
          xor_d = rx_data;
          bad_d = 1'b0;
        end
        ST_DATA: xor_d = xor_q ^ rx_data;
        ST_CHK:  bad_d = (rx_data != xor_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xor_q <= '0;
      bad_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      bad_q <= bad_d;
    end
  end

  assign chk_bad = bad_q;
`else
  localparam state_e ST_AFTER = ST_COMMIT;

  assign chk_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    funct_d     = funct_q;
    sh_d        = sh_q;
    bc_d        = bc_q;
    regs_d      = regs_q;
    wr_idx_d    = wr_idx_q;
    wr_pulse_d  = 1'b0;
    err_pulse_d = 1'b0;
    unique case (state_q)
      ST_FUNC: begin
        if (accept) begin
          funct_d = rx_data;
          sh_d    = '0;
          bc_d    = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (timeout) begin
          err_pulse_d = 1'b1;
          state_d     = ST_FUNC;
        end else if (accept) begin
          sh_d = (sh_q << 8) | DATA_W'(rx_data);
          bc_d = bc_q + BC_W'(1);
          if (last_data) state_d = ST_AFTER;
        end
      end
      ST_CHK: begin
        if (timeout) begin
          err_pulse_d = 1'b1;
          state_d     = ST_FUNC;
        end else if (accept) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_FUNC;
        if (chk_bad || funct_hi) begin
          err_pulse_d = 1'b1;
        end else if (funct_q != FUNCT_NOP) begin
          wr_pulse_d = 1'b1;
          wr_idx_d   = funct_q - 8'd1;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (funct_q == 8'(i + 1)) regs_d[i*DATA_W +: DATA_W] = sh_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_FUNC;
      funct_q     <= '0;
      sh_q        <= '0;
      bc_q        <= '0;
      regs_q      <= RST_VALS;
      wr_idx_q    <= '0;
      wr_pulse_q  <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct_q     <= funct_d;
      sh_q        <= sh_d;
      bc_q        <= bc_d;
      regs_q      <= regs_d;
      wr_idx_q    <= wr_idx_d;
      wr_pulse_q  <= wr_pulse_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign cfg_regs  = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign err_pulse = err_pulse_q;
  assign wr_idx    = wr_idx_q;
  assign busy      = (state_q != ST_FUNC);

endmodule

// File: tb/tb_cfg_cmd_parser.sv
// Bench for cfg_cmd_parser: frame-level reference model, per-cycle compare,
// directed test-plan frames with literal pins, then randomized traffic.
module tb_cfg_cmd_parser;

  localparam int TO   = 12;
  localparam int NREG = 7;
`ifdef CFG_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [111:0] cfg_regs;
  logic         wr_pulse;
  logic [7:0]   wr_idx;
  logic         err_pulse;
  logic         busy;

  cfg_cmd_parser #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cfg_regs  (cfg_regs),
    .wr_pulse  (wr_pulse),
    .wr_idx    (wr_idx),
    .err_pulse (err_pulse),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: collects accepted bytes of the current frame.
  logic [7:0] q[$];
  int         idle;
  bit         commit;
  int         mregs[NREG];
  bit         e_wr, e_err;
  int         e_idx;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      idle   = 0;
      commit = 0;
      mregs  = '{0, 10, 20, 30, 5, 10, 1000};
      e_wr   = 0;
      e_err  = 0;
      e_idx  = 0;
    end else begin
      e_wr  = 0;
      e_err = 0;
      if (commit) begin
        int f, dv;
        bit bad;
        f   = int'(q[0]);
        dv  = int'(q[1]) * 256 + int'(q[2]);
        bad = 0;
`ifdef CFG_CHECKSUM_EN
        bad = (q[3] != (q[0] ^ q[1] ^ q[2]));
`endif
        if (bad || f > NREG) begin
          e_err = 1;
        end else if (f != 0) begin
          mregs[f-1] = dv;
          e_wr       = 1;
          e_idx      = f - 1;
        end
        q.delete();
        commit = 0;
      end else if (q.size() > 0 && idle == TO) begin
        e_err = 1;
        q.delete();
      end else if (rx_valid) begin
        q.push_back(rx_data);
        idle = 0;
        if (q.size() == FLEN) commit = 1;
      end else if (q.size() > 0) begin
        idle++;
      end
    end
  end

  int wr_seen = 0;
  int err_seen = 0;
  int rdy_low = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NREG; i++)
        check($sformatf("reg%0d", i), 32'(cfg_regs[i*16 +: 16]), mregs[i]);
      check("wr_pulse", 32'(wr_pulse), 32'(e_wr));
      check("err_pulse", 32'(err_pulse), 32'(e_err));
      check("wr_idx", 32'(wr_idx), e_idx);
      check("busy", 32'(busy), 32'(q.size() > 0 || commit));
      check("rx_ready", 32'(rx_ready), 32'(!commit));
      if (wr_pulse === 1'b1) wr_seen++;
      if (err_pulse === 1'b1) err_seen++;
      if (rx_ready === 1'b0) rdy_low++;
    end
  end

  function automatic logic [31:0] rg(input int i);
    return 32'(cfg_regs[i*16 +: 16]);
  endfunction

  task automatic tick(input bit v, input logic [7:0] d, output bit acc);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    acc      = v && (rx_ready === 1'b1);
    @(posedge clk);
  endtask

  task automatic idle_n(input int n);
    bit a;
    repeat (n) tick(1'b0, 8'h00, a);
  endtask

  task automatic put_byte(input logic [7:0] b, input int gap);
    bit a;
    int n;
    idle_n(gap);
    n = 0;
    do begin
      tick(1'b1, b, a);
      n++;
    end while (!a && n < 8);
    if (!a) begin
      errors++;
      checks++;
      $display("FAIL stall: byte %0h not accepted in 8 cycles", b);
    end
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 3);
    if (r == 17) return TO - 1;
    if (r == 18) return TO;
    return TO + 1;
  endfunction

  task automatic send_frame(input logic [7:0] f, input logic [15:0] d,
                            input bit rnd, input bit bad);
    put_byte(f, rnd ? rgap() : 0);
    put_byte(d[15:8], rnd ? rgap() : 0);
    put_byte(d[7:0], rnd ? rgap() : 0);
`ifdef CFG_CHECKSUM_EN
    put_byte(f ^ d[15:8] ^ d[7:0] ^ {7'd0, bad}, rnd ? rgap() : 0);
`else
    if (bad) put_byte(8'h00, 0);
`endif
  endtask

  initial begin
    int w0, e0, r0;
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    check("rst_reg6", rg(6), 1000);
    check("rst_reg0", rg(0), 0);
    check("rst_reg3", rg(3), 30);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(rx_ready), 1);
    @(negedge clk);
    #2 rstn = 1'b1;

    send_frame(8'h01, 16'h1234, 0, 0);
    idle_n(2);
    #1;
    check("f1_reg0", rg(0), 32'h1234);
    check("f1_idx", 32'(wr_idx), 0);
    check("f1_reg6", rg(6), 1000);
    check("f1_wrs", wr_seen, 1);
    check("model_reg0", mregs[0], 32'h1234);

    r0 = rdy_low;
    send_frame(8'h07, 16'h0005, 0, 0);
    send_frame(8'h02, 16'h000A, 0, 0);
    idle_n(2);
    #1;
    check("hh_reg6", rg(6), 5);
    check("hh_reg1", rg(1), 10);
    check("hh_rdylow", rdy_low - r0, 2);
    check("hh_idx", 32'(wr_idx), 1);

    w0 = wr_seen;
    e0 = err_seen;
    send_frame(8'h09, 16'hAABB, 0, 0);
    idle_n(2);
    #1;
    check("oor_err", err_seen - e0, 1);
    check("oor_busy", 32'(busy), 0);
    send_frame(8'h00, 16'hFFFF, 0, 0);
    idle_n(2);
    #1;
    check("nop_err", err_seen - e0, 1);
    check("nop_wr", wr_seen - w0, 0);
    check("nop_reg0", rg(0), 32'h1234);

    e0 = err_seen;
    put_byte(8'h03, 0);
    put_byte(8'h56, 0);
    idle_n(TO + 1);
    idle_n(1);
    #1;
    check("to_err", err_seen - e0, 1);
    check("to_reg2", rg(2), 20);
    put_byte(8'h03, 0);
    put_byte(8'h00, TO - 1);
    put_byte(8'h2A, TO - 1);
    idle_n(2);
    #1;
    check("resync_reg2", rg(2), 32'h2A);
    check("model_reg2", mregs[2], 32'h2A);
    e0 = err_seen;
    put_byte(8'h06, 0);
    put_byte(8'h11, 0);
    put_byte(8'h22, TO);
    idle_n(2);
    #1;
    check("drop_err", err_seen - e0, 1);
    check("drop_reg5", rg(5), 10);
    check("drop_busy", 32'(busy), 0);

`ifdef CFG_CHECKSUM_EN
    e0 = err_seen;
    send_frame(8'h04, 16'h0007, 0, 0);
    idle_n(2);
    #1;
    check("ck_reg3", rg(3), 7);
    send_frame(8'h04, 16'h0009, 0, 1);
    idle_n(2);
    #1;
    check("ck_bad_err", err_seen - e0, 1);
    check("ck_bad_reg3", rg(3), 7);
`endif

    put_byte(8'h05, 0);
    put_byte(8'h12, 0);
    @(negedge clk);
    #2;
    rx_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    check("mr_reg4", rg(4), 5);
    check("mr_reg0", rg(0), 0);
    check("mr_busy", 32'(busy), 0);
    @(negedge clk);
    #2 rstn = 1'b1;
    send_frame(8'h05, 16'h1234, 0, 0);
    idle_n(2);
    #1;
    check("mr_next_reg4", rg(4), 32'h1234);
    check("mr_next_idx", 32'(wr_idx), 4);

    for (int k = 0; k < 250; k++) begin
      send_frame(8'($urandom_range(0, 9)), 16'($urandom),
                 1, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle_n($urandom_range(1, 4));
    end
    idle_n(TO + 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_cmd_parser.md
# cfg_cmd_parser

Parametrised byte-stream command parser that decodes framed write commands into a bank of configuration registers. It is the configuration front end between the byte-wide host link (UART/SPI receiver) and the timing cores, which consume delay, duty-cycle and sub-clock settings. Compared with the fixed 3-byte parser, it adds:
- configurable data width and register count;
- a valid/ready handshake;
- an inter-byte timeout;
- range checking;
- an optional checksum;
- write/error status strobes.

## Interface
- DATA_W, 16 — register width in bits; must be a multiple of 8 (8..32)
- NUM_REGS, 7 — number of configuration registers (1..254)
- RST_VALS, {16'd1000,16'd10,16'd5,16'd30,16'd20,16'd10,16'd0} — NUM_REGS*DATA_W reset image; reg i at bits [i*DATA_W +: DATA_W]
- TIMEOUT_CYC, 1000 — idle cycles allowed between bytes of one frame; 0 disables the timeout
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  parser can accept a byte this cycle
- cfg_regs  out  NUM_REGS*DATA_W  register bank, packed as RST_VALS
- wr_pulse  out  1  one-cycle strobe: a register was written this cycle
- wr_idx  out  8  index of the register written; held until the next write
- err_pulse  out  1  one-cycle strobe: frame discarded
- busy  out  1  frame in progress (state ≠ FUNC)

## Operation
- Frame format: funct byte, then NB = DATA_W/8 data bytes MSB first, then one checksum byte (CFG_CHECKSUM_EN only).
- A byte is accepted on a rising edge when rx_valid && rx_ready.
- funct decode:
  - 0x00 = NOP: the data bytes are still consumed; no write, no error.
  - 0x01..NUM_REGS: targets reg funct−1.
  - Any other value: out of range; the frame is consumed and then discarded with err_pulse.
- States:
  - FUNC: accept a byte, latch funct, clear the shift register and byte counter → DATA.
  - DATA: shift each byte into a DATA_W shift register (new byte into LSBs), incrementing the counter. On byte NB → CHK if CFG_CHECKSUM_EN, else → COMMIT.
  - CHK: accept the checksum byte → COMMIT.
  - COMMIT: rx_ready=0. If the frame is valid and funct≠0, write the shift register to reg funct−1, assert wr_pulse and update wr_idx. Out-of-range funct or checksum mismatch asserts err_pulse instead. Always → FUNC.
- Timeout: an idle counter resets on every accepted byte and increments each cycle in DATA/CHK. When it reaches TIMEOUT_CYC, discard the frame, assert err_pulse for one cycle, → FUNC. No register changes.
- The register bank changes only in COMMIT; a partial frame never alters cfg_regs.
- wr_pulse and err_pulse are never asserted in the same cycle.

## Timing
- Reset values:
  - state=FUNC, rx_ready=1, busy=0
  - cfg_regs=RST_VALS
  - wr_pulse=0, err_pulse=0, wr_idx=0
  - idle counter and byte counter = 0
- rx_ready = 1 in FUNC/DATA/CHK, 0 in COMMIT.
- Latency: last byte accepted at edge N; COMMIT occupies cycle N→N+1; cfg_regs and wr_pulse become visible after edge N+1.
- Minimum frame period is NB+2 cycles (NB+3 with checksum). The host may present the next funct byte during COMMIT; it is held off one cycle by rx_ready.
- Timeout fires on the edge where the idle count equals TIMEOUT_CYC. A byte arriving on that same edge is dropped, and the parser returns to FUNC.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- rx_valid held high continuously: one byte per ready cycle, no loss.

## Configuration
- CFG_CHECKSUM_EN defined:
  - A trailing checksum byte is required.
  - Checksum = XOR of funct and all data bytes.
  - Mismatch → err_pulse in COMMIT, no write.
- CFG_CHECKSUM_EN undefined:
  - The CHK state and XOR accumulator are absent.
  - Frames are NB+1 bytes.

## Structure
- Shared package cfg_pkg:
  - state encoding (ST_FUNC, ST_DATA, ST_CHK, ST_COMMIT)
  - FUNCT_NOP = 8'h00
  - default DATA_W / NUM_REGS constants
  - clog2 helper for the counter widths
- One sub-module is natural: cfg_idle_timer (parametrised down-counter with clear/enable/expire), also reusable by the link receivers.

## Test plan
- Reset, then frame 01 12 34 (no checksum) → one cycle after the last byte, reg0=0x1234, wr_pulse for 1 cycle, wr_idx=0; all other regs keep RST_VALS (reg6=1000).
- Frame 07 00 05 sent with rx_valid held high → reg6=5; rx_ready low for exactly 1 cycle after the last byte; a following 02 00 0A frame also lands (reg1=10).
- Frame 09 AA BB with NUM_REGS=7 → err_pulse for 1 cycle, no register change, back to FUNC; frame 00 FF FF → no write, no error.
- Send 03 56 then idle TIMEOUT_CYC cycles → err_pulse; then 03 00 2A → reg2=0x002A, proving resync.
- With CFG_CHECKSUM_EN: 04 00 07 03 (XOR correct) → reg3=7; 04 00 07 00 → err_pulse, reg3 stays 7.
- Assert rstn low between the 2nd and 3rd byte of 05 12 34 → reg4 keeps RST_VALS (5), busy=0; the next full frame decodes correctly.
